tl_data_upsizer_nr: RTL and testbench

TL_DATA_UPSIZER_NR -- requirements
Module: tl_data_upsizer_nr

---
 rtl/tl_data_upsizer_nr_if.sv | 59 +++++
 rtl/tl_data_upsizer_nr.sv | 228 ++++++++++++++++++++++
 tb/tb_tl_data_upsizer_nr.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_data_upsizer_nr_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tl_data_upsizer_nr_if                                           |
// | Purpose  : One TileLink UH A/D channel pair carried as a single bundle.    |
// |            A channel: a_valid/a_ready handshake plus payload struct a.     |
// |            D channel: d_valid/d_ready handshake plus payload struct d.     |
// | Modports : master - issues A requests and consumes D responses           |
// |            slave  - consumes A requests and issues D responses           |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface tl_data_upsizer_nr_if #(
  parameter int DataWidth   = 32,
  parameter int AddrWidth   = 56,
  parameter int SourceWidth = 4,
  parameter int SizeWidth   = 3,
  parameter int SinkWidth   = 1
);

  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             param;
    logic [SizeWidth-1:0]   size;
    logic [SourceWidth-1:0] source;
    logic [AddrWidth-1:0]   address;
    logic [DataWidth/8-1:0] mask;
    logic [DataWidth-1:0]   data;
    logic                   corrupt;
  } a_chan_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [1:0]             param;
    logic [SizeWidth-1:0]   size;
    logic [SourceWidth-1:0] source;
    logic [SinkWidth-1:0]   sink;
    logic                   denied;
    logic                   corrupt;
    logic [DataWidth-1:0]   data;
  } d_chan_t;

  logic    a_valid;
  logic    a_ready;
  a_chan_t a;
  logic    d_valid;
  logic    d_ready;
  d_chan_t d;

  modport master (
    output a_valid, a, d_ready,
    input  a_ready, d_valid, d
  );

  modport slave (
    input  a_valid, a, d_ready,
    output a_ready, d_valid, d
  );

endinterface
`default_nettype wire

// File: rtl/tl_data_upsizer_nr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tl_data_upsizer_nr                                              |
// | Purpose  : TileLink UH data-width upsizer (narrow host, wide device).     |
// |            A: host beats are gathered into their byte lanes and issued as |
// |            one device beat per group, with zero added latency.           |
// |            D: wide response beats are split back into host beats using a |
// |            per-source lane offset captured on the request.               |
// | Ports    : clk_i  - clock                                                 |
// |            rst_i  - synchronous active-high reset                         |
// |            host   - slave side, HostDataWidth wide                       |
// |            device - master side, DeviceDataWidth wide                    |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tl_data_upsizer_nr #(
  parameter int HostDataWidth   = 32,
  parameter int DeviceDataWidth = 128,
  parameter int AddrWidth       = 56,
  parameter int SourceWidth     = 4,
  parameter int MaxSize         = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tl_data_upsizer_nr_if.slave  host,
  tl_data_upsizer_nr_if.master device
);

  localparam int Ratio  = DeviceDataWidth / HostDataWidth;
  localparam int HBytes = HostDataWidth / 8;
  localparam int DBytes = DeviceDataWidth / 8;
  localparam int HNB    = $clog2(HBytes);
  localparam int DNB    = $clog2(DBytes);
  localparam int LW     = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam int SzW    = $clog2(MaxSize + 1);
  localparam int MW     = (MaxSize > HNB) ? (MaxSize - HNB) : 1;

  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpAccessAckData = 3'd1;

  if ((Ratio < 2) || (Ratio > 8) || ((Ratio & (Ratio - 1)) != 0) ||
      ((DeviceDataWidth % HostDataWidth) != 0) || (AddrWidth < DNB)) begin : g_bad_params
    $fatal(1, "tl_data_upsizer_nr: width ratio must be a power of two in 2..8");
  end

  // Index of the final host beat within one device-beat group.
  function automatic logic [LW-1:0] group_last(input logic [SzW-1:0] sz);
    int gl;
    gl = int'(sz) - HNB;
    if (gl < 0)  gl = 0;
    if (gl > LW) gl = LW;
    return LW'((1 << gl) - 1);
  endfunction

  // Index of the final host beat of a whole message.
  function automatic logic [MW-1:0] msg_last(input logic [SzW-1:0] sz);
    int ml;
    ml = int'(sz) - HNB;
    if (ml < 0)  ml = 0;
    if (ml > MW) ml = MW;
    return MW'((1 << ml) - 1);
  endfunction

  // ---------------------------------------------------------------------------
  // A channel state
  // ---------------------------------------------------------------------------
  logic [LW-1:0]            a_cnt_q,   a_cnt_d;
  logic [MW-1:0]            a_msg_q,   a_msg_d;
  logic                     corrupt_q, corrupt_d;
  logic [HostDataWidth-1:0] gdata_q [Ratio-1];
  logic [HostDataWidth-1:0] gdata_d [Ratio-1];
  logic [HBytes-1:0]        gmask_q [Ratio-1];
  logic [HBytes-1:0]        gmask_d [Ratio-1];

  // Per-source lane offset; deliberately not reset, rewritten per request.
  logic [LW-1:0]            offset_q [2**SourceWidth];
  logic                     offset_we;
  logic [LW-1:0]            offset_wdata;

  logic                       a_is_get;
  logic [LW-1:0]              a_glast;
  logic [MW-1:0]              a_mlast;
  logic                       a_final;
  logic                       a_fire;
  logic [LW-1:0]              a_base;
  logic [DeviceDataWidth-1:0] a_data;
  logic [DBytes-1:0]          a_lane_mask;
  logic [DBytes-1:0]          a_align_mask;
  int                         a_csz;

  // ---------------------------------------------------------------------------
  // D channel state
  // ---------------------------------------------------------------------------
  logic [LW-1:0] d_cnt_q, d_cnt_d;
  logic          d_is_data;
  logic [LW-1:0] d_glast;
  logic          d_final;
  logic [LW-1:0] d_lane;

  // A handshake: non-final sub-beats are absorbed locally; the final one is
  // forwarded combinationally so the device sees the group with no delay.
  always_comb begin
    a_is_get       = (host.a.opcode == OpGet);
    a_glast        = a_is_get ? '0 : group_last(host.a.size);
    a_mlast        = a_is_get ? '0 : msg_last(host.a.size);
    a_final        = (a_cnt_q == a_glast);
    // Readies are also held low in reset so no beat is consumed then.
    host.a_ready   = !rst_i && (a_final ? device.a_ready : 1'b1);
    device.a_valid = !rst_i && a_final && host.a_valid;
    a_fire         = host.a_valid && host.a_ready;
  end

  // A datapath: place gathered beats and the live beat into their lanes.
  always_comb begin
    a_base      = host.a.address[DNB-1:HNB];
    a_data      = '0;
    a_lane_mask = '0;
    for (int j = 0; j < Ratio - 1; j++) begin
      if (LW'(j) < a_cnt_q) begin
        a_data[(a_base | LW'(j)) * HostDataWidth +: HostDataWidth] = gdata_q[j];
        a_lane_mask[(a_base | LW'(j)) * HBytes +: HBytes]          = gmask_q[j];
      end
    end
    a_data[(a_base | a_cnt_q) * HostDataWidth +: HostDataWidth] = host.a.data;
    a_lane_mask[(a_base | a_cnt_q) * HBytes +: HBytes]          = host.a.mask;

    // Bytes covered by the naturally aligned message window within one beat.
    a_csz = int'(host.a.size);
    if (a_csz > DNB) a_csz = DNB;
    for (int b = 0; b < DBytes; b++) begin
      a_align_mask[b] = (((b ^ int'(host.a.address[DNB-1:0])) >> a_csz) == 0);
    end

    device.a.opcode  = host.a.opcode;
    device.a.param   = host.a.param;
    device.a.size    = host.a.size;
    device.a.source  = host.a.source;
    device.a.address = host.a.address;
    // A Get carries no data lanes, so its mask is the aligned window alone.
    device.a.mask    = a_is_get ? a_align_mask : (a_lane_mask & a_align_mask);
    device.a.data    = a_data;
    device.a.corrupt = corrupt_q | host.a.corrupt;
  end

  // A next state.
  always_comb begin
    a_cnt_d      = a_cnt_q;
    a_msg_d      = a_msg_q;
    corrupt_d    = corrupt_q;
    gdata_d      = gdata_q;
    gmask_d      = gmask_q;
    offset_we    = 1'b0;
    offset_wdata = host.a.address[DNB-1:HNB];
    if (a_fire) begin
      offset_we = (a_msg_q == '0);
      a_msg_d   = (a_msg_q == a_mlast) ? '0 : (a_msg_q + 1'b1);
      if (a_final) begin
        a_cnt_d   = '0;
        corrupt_d = 1'b0;
        for (int j = 0; j < Ratio - 1; j++) begin
          gdata_d[j] = '0;
          gmask_d[j] = '0;
        end
      end else begin
        for (int j = 0; j < Ratio - 1; j++) begin
          if (a_cnt_q == LW'(j)) begin
            gdata_d[j] = host.a.data;
            gmask_d[j] = host.a.mask;
          end
        end
        a_cnt_d   = a_cnt_q + 1'b1;
        corrupt_d = corrupt_q | host.a.corrupt;
      end
    end
  end

  // D path: split a wide data beat into host beats, releasing the device
  // beat only together with the last host beat taken from it.
  always_comb begin
    d_is_data      = (device.d.opcode == OpAccessAckData);
    d_glast        = d_is_data ? group_last(device.d.size) : '0;
    d_final        = (d_cnt_q == d_glast);
    d_lane         = offset_q[device.d.source] | d_cnt_q;
    host.d_valid   = !rst_i && device.d_valid;
    device.d_ready = !rst_i && d_final && host.d_ready;

    host.d.opcode  = device.d.opcode;
    host.d.param   = device.d.param;
    host.d.size    = device.d.size;
    host.d.source  = device.d.source;
    host.d.sink    = device.d.sink;
    host.d.denied  = device.d.denied;
    host.d.corrupt = device.d.corrupt;
    host.d.data    = device.d.data[d_lane * HostDataWidth +: HostDataWidth];

    d_cnt_d = d_cnt_q;
    if (host.d_valid && host.d_ready) begin
      d_cnt_d = d_final ? '0 : (d_cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_cnt_q   <= '0;
      a_msg_q   <= '0;
      corrupt_q <= 1'b0;
      d_cnt_q   <= '0;
      for (int j = 0; j < Ratio - 1; j++) begin
        gdata_q[j] <= '0;
        gmask_q[j] <= '0;
      end
    end else begin
      a_cnt_q   <= a_cnt_d;
      a_msg_q   <= a_msg_d;
      corrupt_q <= corrupt_d;
      d_cnt_q   <= d_cnt_d;
      gdata_q   <= gdata_d;
      gmask_q   <= gmask_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (offset_we) begin
      offset_q[host.a.source] <= offset_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tl_data_upsizer_nr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tl_data_upsizer_nr                                           |
// | Purpose  : Directed self-checking bench for tl_data_upsizer_nr (32->128). |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_tl_data_upsizer_nr;

  localparam int HW  = 32;
  localparam int DW  = 128;
  localparam int AW  = 56;
  localparam int SW  = 4;
  localparam int MS  = 6;
  localparam int SZW = 3;

  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] PUT_PART = 3'd1;
  localparam logic [2:0] GET      = 3'd4;
  localparam logic [2:0] ACK      = 3'd0;
  localparam logic [2:0] ACK_DATA = 3'd1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tl_data_upsizer_nr_if #(.DataWidth(HW), .AddrWidth(AW), .SourceWidth(SW), .SizeWidth(SZW)) host_if ();
  tl_data_upsizer_nr_if #(.DataWidth(DW), .AddrWidth(AW), .SourceWidth(SW), .SizeWidth(SZW)) dev_if ();

  tl_data_upsizer_nr #(
    .HostDataWidth  (HW),
    .DeviceDataWidth(DW),
    .AddrWidth      (AW),
    .SourceWidth    (SW),
    .MaxSize        (MS)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .host  (host_if),
    .device(dev_if)
  );

  typedef struct packed {
    logic         valid;
    logic [2:0]   op;
    logic [2:0]   size;
    logic [3:0]   src;
    logic [55:0]  addr;
    logic [3:0]   mask;
    logic [31:0]  data;
    logic         cor;
    logic         dready;
    logic         exp_hready;
    logic         exp_dvalid;
    logic [127:0] exp_data;
    logic [15:0]  exp_mask;
    logic         exp_cor;
  } a_vec_t;

  a_vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [2:0] op, input logic [2:0] sz,
                         input logic [3:0] src, input logic [55:0] addr,
                         input logic [3:0] msk, input logic [31:0] dat, input logic cor);
    host_if.a_valid   = v;
    host_if.a.opcode  = op;
    host_if.a.param   = 3'd0;
    host_if.a.size    = sz;
    host_if.a.source  = src;
    host_if.a.address = addr;
    host_if.a.mask    = msk;
    host_if.a.data    = dat;
    host_if.a.corrupt = cor;
  endtask

  task automatic drive_d(input logic v, input logic [2:0] op, input logic [2:0] sz,
                         input logic [3:0] src, input logic den, input logic [127:0] dat);
    dev_if.d_valid   = v;
    dev_if.d.opcode  = op;
    dev_if.d.param   = 2'd0;
    dev_if.d.size    = sz;
    dev_if.d.source  = src;
    dev_if.d.sink    = 1'b1;
    dev_if.d.denied  = den;
    dev_if.d.corrupt = 1'b0;
    dev_if.d.data    = dat;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic void add_a(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                                input logic [55:0] addr, input logic [3:0] msk,
                                input logic [31:0] dat, input logic cor, input logic dready,
                                input logic ehr, input logic edv, input logic [127:0] edata,
                                input logic [15:0] emask, input logic ecor);
    a_vec_t v;
    v.valid = 1'b1; v.op = op; v.size = sz; v.src = src; v.addr = addr; v.mask = msk;
    v.data = dat; v.cor = cor; v.dready = dready; v.exp_hready = ehr; v.exp_dvalid = edv;
    v.exp_data = edata; v.exp_mask = emask; v.exp_cor = ecor;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [127:0] exp128;

    // ---------------- vector table ----------------
    // 64-byte PutFull: four device beats of four host beats each.
    for (int i = 0; i < 16; i++) begin
      if ((i % 4) == 3) begin
        exp128 = {32'(i), 32'(i - 1), 32'(i - 2), 32'(i - 3)};
        if (i == 3)
          add_a(PUT_FULL, 3'd6, 4'd1, 56'h40, 4'hF, 32'(i), 1'b0, 1'b0,
                1'b0, 1'b1, exp128, 16'hFFFF, 1'b0);
        add_a(PUT_FULL, 3'd6, 4'd1, 56'h40, 4'hF, 32'(i), 1'b0, 1'b1,
              1'b1, 1'b1, exp128, 16'hFFFF, 1'b0);
      end else begin
        add_a(PUT_FULL, 3'd6, 4'd1, 56'h40, 4'hF, 32'(i), 1'b0, 1'b1,
              1'b1, 1'b0, '0, '0, 1'b0);
      end
    end
    // Get of 4 bytes at 0x0C lands in lane 3.
    add_a(GET, 3'd2, 4'd5, 56'h0C, 4'hF, 32'h0, 1'b0, 1'b1,
          1'b1, 1'b1, '0, 16'hF000, 1'b0);
    // 8-byte PutFull at 0x08 with a corrupt first beat.
    add_a(PUT_FULL, 3'd3, 4'd2, 56'h08, 4'hF, 32'hAAAA0000, 1'b1, 1'b1,
          1'b1, 1'b0, '0, '0, 1'b0);
    add_a(PUT_FULL, 3'd3, 4'd2, 56'h08, 4'hF, 32'hBBBB1111, 1'b0, 1'b1,
          1'b1, 1'b1, 128'hBBBB1111_AAAA0000_00000000_00000000, 16'hFF00, 1'b1);
    // Next message must start with corrupt cleared.
    add_a(PUT_FULL, 3'd2, 4'd2, 56'h04, 4'hF, 32'hCCCC2222, 1'b0, 1'b1,
          1'b1, 1'b1, 128'h00000000_00000000_CCCC2222_00000000, 16'h00F0, 1'b0);
    add_a(PUT_PART, 3'd2, 4'd3, 56'h00, 4'h3, 32'h00001234, 1'b0, 1'b1,
          1'b1, 1'b1, 128'h00000000_00000000_00000000_00001234, 16'h0003, 1'b0);
    add_a(PUT_PART, 3'd1, 4'd3, 56'h06, 4'hC, 32'h56780000, 1'b0, 1'b1,
          1'b1, 1'b1, 128'h00000000_00000000_56780000_00000000, 16'h00C0, 1'b0);
    // Get larger than a device beat: one request beat, full mask.
    add_a(GET, 3'd6, 4'd6, 56'h40, 4'hF, 32'h0, 1'b0, 1'b1,
          1'b1, 1'b1, '0, 16'hFFFF, 1'b0);

    // ---------------- reset behaviour ----------------
    rst = 1'b1;
    dev_if.a_ready  = 1'b1;
    host_if.d_ready = 1'b1;
    drive_a(1'b1, GET, 3'd2, 4'd0, 56'h0, 4'hF, 32'h0, 1'b0);
    drive_d(1'b1, ACK_DATA, 3'd2, 4'd0, 1'b0, '0);
    @(negedge clk);
    chk("reset dev_a_valid", 128'(dev_if.a_valid), 128'd0);
    chk("reset host_d_valid", 128'(host_if.d_valid), 128'd0);
    next_cycle();
    rst = 1'b0;
    drive_a(1'b0, PUT_FULL, 3'd0, 4'd0, 56'h0, 4'h0, 32'h0, 1'b0);
    drive_d(1'b0, ACK, 3'd0, 4'd0, 1'b0, '0);
    next_cycle();

    // ---------------- table-driven A vectors ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      drive_a(vecs[i].valid, vecs[i].op, vecs[i].size, vecs[i].src, vecs[i].addr,
              vecs[i].mask, vecs[i].data, vecs[i].cor);
      dev_if.a_ready = vecs[i].dready;
      @(negedge clk);
      chk($sformatf("vec%0d host_a_ready", i), 128'(host_if.a_ready), 128'(vecs[i].exp_hready));
      chk($sformatf("vec%0d dev_a_valid", i), 128'(dev_if.a_valid), 128'(vecs[i].exp_dvalid));
      if (vecs[i].exp_dvalid) begin
        chk($sformatf("vec%0d dev_a_data", i), dev_if.a.data, vecs[i].exp_data);
        chk($sformatf("vec%0d dev_a_mask", i), 128'(dev_if.a.mask), 128'(vecs[i].exp_mask));
        chk($sformatf("vec%0d dev_a_corrupt", i), 128'(dev_if.a.corrupt), 128'(vecs[i].exp_cor));
        chk($sformatf("vec%0d dev_a_source", i), 128'(dev_if.a.source), 128'(vecs[i].src));
      end
      next_cycle();
    end
    drive_a(1'b0, PUT_FULL, 3'd0, 4'd0, 56'h0, 4'h0, 32'h0, 1'b0);
    dev_if.a_ready = 1'b1;

    // ---------------- single-beat read response (source 5 -> lane 3) ----------------
    drive_d(1'b1, ACK_DATA, 3'd2, 4'd5, 1'b0,
            {32'h0000CAFE, 32'h11111111, 32'h22222222, 32'h33333333});
    @(negedge clk);
    chk("cafe host_d_valid", 128'(host_if.d_valid), 128'd1);
    chk("cafe host_d_data", 128'(host_if.d.data), 128'h0000CAFE);
    chk("cafe dev_d_ready", 128'(dev_if.d_ready), 128'd1);
    chk("cafe host_d_source", 128'(host_if.d.source), 128'd5);
    next_cycle();
    drive_d(1'b0, ACK, 3'd0, 4'd0, 1'b0, '0);

    // ---------------- device backpressure on the final sub-beat ----------------
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, PUT_FULL, 3'd4, 4'd4, 56'h10, 4'hF, 32'h10 + 32'(i), 1'b0);
      @(negedge clk);
      chk($sformatf("stall beat%0d dev_a_valid", i), 128'(dev_if.a_valid), 128'd0);
      next_cycle();
    end
    drive_a(1'b1, PUT_FULL, 3'd4, 4'd4, 56'h10, 4'hF, 32'h13, 1'b0);
    for (int c = 0; c < 6; c++) begin
      dev_if.a_ready = (c == 5);
      @(negedge clk);
      chk($sformatf("stall c%0d host_a_ready", c), 128'(host_if.a_ready), 128'(c == 5));
      chk($sformatf("stall c%0d dev_a_valid", c), 128'(dev_if.a_valid), 128'd1);
      chk($sformatf("stall c%0d dev_a_data", c), dev_if.a.data,
          128'h00000013_00000012_00000011_00000010);
      next_cycle();
    end
    drive_a(1'b0, PUT_FULL, 3'd0, 4'd0, 56'h0, 4'h0, 32'h0, 1'b0);
    dev_if.a_ready = 1'b1;

    // ---------------- out-of-order responses via the offset table ----------------
    drive_a(1'b1, GET, 3'd2, 4'd1, 56'h04, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    chk("get src1 mask", 128'(dev_if.a.mask), 128'h00F0);
    next_cycle();
    drive_a(1'b1, GET, 3'd2, 4'd2, 56'h08, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    chk("get src2 mask", 128'(dev_if.a.mask), 128'h0F00);
    next_cycle();
    // Source 3 request accepted in the same cycle as the source 2 response.
    drive_a(1'b1, GET, 3'd2, 4'd3, 56'h0C, 4'hF, 32'h0, 1'b0);
    drive_d(1'b1, ACK_DATA, 3'd2, 4'd2, 1'b0, 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000);
    @(negedge clk);
    chk("ooo src3 dev_a_valid", 128'(dev_if.a_valid), 128'd1);
    chk("ooo src2 host_d_data", 128'(host_if.d.data), 128'hDDDD0002);
    chk("ooo src2 dev_d_ready", 128'(dev_if.d_ready), 128'd1);
    next_cycle();
    drive_a(1'b0, PUT_FULL, 3'd0, 4'd0, 56'h0, 4'h0, 32'h0, 1'b0);
    drive_d(1'b1, ACK_DATA, 3'd2, 4'd1, 1'b0, 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000);
    @(negedge clk);
    chk("ooo src1 host_d_data", 128'(host_if.d.data), 128'hDDDD0001);
    next_cycle();
    drive_d(1'b1, ACK_DATA, 3'd2, 4'd3, 1'b0, 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000);
    @(negedge clk);
    chk("ooo src3 host_d_data", 128'(host_if.d.data), 128'hDDDD0003);
    next_cycle();
    drive_d(1'b0, ACK, 3'd0, 4'd0, 1'b0, '0);

    // ---------------- 16-byte response split into four host beats ----------------
    drive_a(1'b1, GET, 3'd4, 4'd7, 56'h00, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    chk("get src7 mask", 128'(dev_if.a.mask), 128'hFFFF);
    next_cycle();
    drive_a(1'b0, PUT_FULL, 3'd0, 4'd0, 56'h0, 4'h0, 32'h0, 1'b0);
    drive_d(1'b1, ACK_DATA, 3'd4, 4'd7, 1'b0, 128'h33333333_22222222_11111111_00000000);
    begin
      logic [31:0] exp_beat [5] = '{32'h00000000, 32'h11111111, 32'h11111111,
                                    32'h22222222, 32'h33333333};
      logic        hrdy     [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic        exp_dr   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int c = 0; c < 5; c++) begin
        host_if.d_ready = hrdy[c];
        @(negedge clk);
        chk($sformatf("split c%0d host_d_valid", c), 128'(host_if.d_valid), 128'd1);
        chk($sformatf("split c%0d host_d_data", c), 128'(host_if.d.data), 128'(exp_beat[c]));
        chk($sformatf("split c%0d dev_d_ready", c), 128'(dev_if.d_ready), 128'(exp_dr[c]));
        chk($sformatf("split c%0d host_d_sink", c), 128'(host_if.d.sink), 128'd1);
        next_cycle();
      end
    end
    host_if.d_ready = 1'b1;

    // ---------------- AccessAck passes as one beat ----------------
    drive_d(1'b1, ACK, 3'd2, 4'd1, 1'b1, '0);
    @(negedge clk);
    chk("ack host_d_valid", 128'(host_if.d_valid), 128'd1);
    chk("ack dev_d_ready", 128'(dev_if.d_ready), 128'd1);
    chk("ack host_d_opcode", 128'(host_if.d.opcode), 128'(ACK));
    chk("ack host_d_denied", 128'(host_if.d.denied), 128'd1);
    next_cycle();
    drive_d(1'b0, ACK, 3'd0, 4'd0, 1'b0, '0);

    // ---------------- reset mid-burst discards the partial group ----------------
    for (int i = 0; i < 2; i++) begin
      drive_a(1'b1, PUT_FULL, 3'd4, 4'd8, 56'h20, 4'hF, 32'hA0 + 32'(i), 1'b0);
      @(negedge clk);
      chk($sformatf("pre-rst beat%0d dev_a_valid", i), 128'(dev_if.a_valid), 128'd0);
      next_cycle();
    end
    rst = 1'b1;
    drive_a(1'b1, GET, 3'd2, 4'd9, 56'h0, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    chk("mid-rst dev_a_valid", 128'(dev_if.a_valid), 128'd0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, PUT_FULL, 3'd4, 4'd8, 56'h20, 4'hF, 32'hB0 + 32'(i), 1'b0);
      @(negedge clk);
      chk($sformatf("post-rst beat%0d dev_a_valid", i), 128'(dev_if.a_valid), 128'(i == 3));
      if (i == 3) begin
        chk("post-rst dev_a_data", dev_if.a.data, 128'h000000B3_000000B2_000000B1_000000B0);
        chk("post-rst dev_a_mask", 128'(dev_if.a.mask), 128'hFFFF);
      end
      next_cycle();
    end
    drive_a(1'b0, PUT_FULL, 3'd0, 4'd0, 56'h0, 4'h0, 32'h0, 1'b0);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
